gate_stim_checker: RTL and testbench
====================================

Name: gate_stim_checker

Overview:
- Self-sequencing stimulus/check stage wrapped around the basic logic-gates block.
- Drives the gate inputs `a`/`b` through all four input combinations.
- Captures the seven gate outputs and compares them against the expected truth table.
- Reports pass/fail, a per-vector failure mask and an error count, so the gate block can be checked in-system without a waveform viewer.

Parameters:
- HOLD_CYCLES, 4: cycles each input vector is held before sampling; a value of 0 is treated as 1.
- NUM_PASSES, 1: number of full 4-vector sweeps per run; minimum 1.
- CNT_W, 8: width of err_count.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  run request, sampled in IDLE or DONE.
- a  output  1  gate input a.
- b  output  1  gate input b.
- obs  input  7  gate outputs {and_out, or_out, not_a, nand_out, nor_out, xor_out, xnor_out}, bit 6 down to bit 0.
- busy  output  1  high while sweeping.
- done  output  1  high from run completion until next start.
- pass  output  1  done && no mismatch in the run.
- vec_idx  output  2  index of the vector currently driven, equal to {a,b}.
- fail_vec  output  4  sticky per-vector mismatch mask; bit i = vector i failed in any pass.
- err_count  output  CNT_W  number of mismatching vector samples, saturating.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. rst asserted at any time, including mid-run, forces every output and all internal state to its reset value.
- Reset values: a=0, b=0, busy=0, done=0, pass=0, vec_idx=0, fail_vec=0, err_count=0, state=IDLE.
- FSM states:
  - IDLE: start=1 at an edge → RUN. That same edge clears fail_vec, err_count, hold counter and pass counter; drives a=0, b=0; sets busy=1.
  - RUN: each vector is held exactly H = max(HOLD_CYCLES,1) cycles.
    - At the edge where hold_cnt == H-1, obs is compared to expected[vec_idx].
    - Expected values: 00→7'h1D, 01→7'h3A, 10→7'h2A, 11→7'h61.
    - On mismatch: fail_vec[vec_idx] is set and err_count increments by 1 (one count per vector sample, not per bit). err_count saturates at all-ones.
    - The same edge advances the vector in the order 00→01→10→11, then wraps to 00 and increments the pass counter.
  - RUN → DONE: on the compare edge of vector 11 in the final pass. On that edge: busy=0, done=1, pass=(no mismatch this run, including this compare), a/b return to 0, vec_idx=0.
  - Total busy cycles per run = 4·H·NUM_PASSES.
  - DONE: outputs held. start=1 → restart exactly as from IDLE; done and pass clear on the same edge.
- start while RUN is ignored; there is no queueing.
- a, b and vec_idx are registered; they change only on clock edges, never combinationally from start.
- obs is assumed stable by the sample edge; the block adds no synchronizer because obs is combinational from a/b in the same clock domain.

Optional Feature:
- Macro: GATE_STIM_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the run.
  - On the mismatching compare edge: fail_vec bit set, err_count=1, busy=0, done=1, pass=0.
  - a, b and vec_idx freeze at the failing vector and hold until restart or reset, so the failing pattern stays applied for debug.
- Undefined: every vector of every pass is checked regardless of failures; a/b return to 0 at DONE.

Test Plan:
- Correct gate block, HOLD_CYCLES=4, NUM_PASSES=1; pulse start one cycle → busy high 16 cycles; {a,b} steps 00,01,10,11 every 4 cycles; then done=1, pass=1, err_count=0, fail_vec=4'b0000.
- obs bit 1 (xor) stuck at 0, NUM_PASSES=2 → vectors 01 and 10 fail each pass; err_count=4, fail_vec=4'b0110, pass=0, done after 32 cycles.
- rst asserted at cycle 6 of a run → a=b=0, busy=0, done=0, err_count=0 immediately (asynchronously); a later start runs cleanly to pass=1.
- start pulsed again at cycle 5 of a run, then pulsed in DONE → the mid-run pulse has no effect, total 16 busy cycles; the DONE pulse clears done/pass on the same edge and restarts at {a,b}=00.
- CNT_W=2, obs forced to 7'h00, NUM_PASSES=2 → err_count saturates at 3, fail_vec=4'b1111.
- GATE_STIM_STOP_ON_FAIL_EN defined, nand output inverted → stop at vector 00 after H cycles; done=1, vec_idx=0, a=b=0 held, err_count=1, fail_vec=4'b0001.

Source files
------------

// File: rtl/gate_stim_checker.sv
// Self-sequencing stimulus/check stage for the 7-output logic-gates block.
// Optional macro GATE_STIM_STOP_ON_FAIL_EN: end the run on the first mismatch and hold that vector.
module gate_stim_checker #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned NUM_PASSES  = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic [6:0]       obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       vec_idx,
    output logic [3:0]       fail_vec,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned H  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam int unsigned NP = (NUM_PASSES == 0) ? 1 : NUM_PASSES;
    localparam int unsigned HW = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [HW-1:0] HLAST = HW'(H - 1);
    localparam logic [PW-1:0] PLAST = PW'(NP - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state, w_state;
    logic [1:0]       r_vec, w_vec;
    logic [HW-1:0]    r_hold, w_hold;
    logic [PW-1:0]    r_pcnt, w_pcnt;
    logic [3:0]       r_fail, w_fail;
    logic [CNT_W-1:0] r_err, w_err;
    logic             r_ok, w_ok;
    logic [6:0]       w_expect;
    logic             w_mism;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_vec   <= '0;
            r_hold  <= '0;
            r_pcnt  <= '0;
            r_fail  <= '0;
            r_err   <= '0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_vec   <= w_vec;
            r_hold  <= w_hold;
            r_pcnt  <= w_pcnt;
            r_fail  <= w_fail;
            r_err   <= w_err;
            r_ok    <= w_ok;
        end
    end

    // Truth table packed as {and, or, not_a, nand, nor, xor, xnor}.
    always_comb begin
        w_expect = 7'h1D;
        unique case (r_vec)
            2'd0: w_expect = 7'h1D;
            2'd1: w_expect = 7'h3A;
            2'd2: w_expect = 7'h2A;
            2'd3: w_expect = 7'h61;
        endcase
    end

    assign w_mism = (obs != w_expect);

    always_comb begin
        w_state = r_state;
        w_vec   = r_vec;
        w_hold  = r_hold;
        w_pcnt  = r_pcnt;
        w_fail  = r_fail;
        w_err   = r_err;
        w_ok    = r_ok;
        case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state = StRun;
                    w_vec   = '0;
                    w_hold  = '0;
                    w_pcnt  = '0;
                    w_fail  = '0;
                    w_err   = '0;
                    w_ok    = 1'b1;
                end
            end
            StRun: begin
                if (r_hold != HLAST) begin
                    w_hold = r_hold + HW'(1);
                end else begin
                    w_hold = '0;
                    if (w_mism) begin
                        w_fail[r_vec] = 1'b1;
                        w_err         = (r_err == '1) ? r_err : r_err + CNT_W'(1);
                        w_ok          = 1'b0;
                    end
`ifdef GATE_STIM_STOP_ON_FAIL_EN
                    if (w_mism) begin
                        w_state = StDone;  // vector left applied for debug
                    end else
`endif
                    if (r_vec == 2'd3) begin
                        w_vec = '0;
                        if (r_pcnt == PLAST) begin
                            w_state = StDone;
                        end else begin
                            w_pcnt = r_pcnt + PW'(1);
                        end
                    end else begin
                        w_vec = r_vec + 2'd1;
                    end
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign a         = r_vec[1];
    assign b         = r_vec[0];
    assign vec_idx   = r_vec;
    assign busy      = (r_state == StRun);
    assign done      = (r_state == StDone);
    assign pass      = done && r_ok;
    assign fail_vec  = r_fail;
    assign err_count = r_err;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench for gate_stim_checker: three instances covering default, HOLD_CYCLES=0 with
// CNT_W=2 saturation, and a two-pass sweep; obs comes from a gate model with injectable faults.
module tb_gate_stim_checker;

`ifdef GATE_STIM_STOP_ON_FAIL_EN
    localparam int XOR1_N = 8,  XOR1_ERR = 1, XOR1_FAIL = 2,  XOR1_AB = 1;
    localparam int NAND_N = 4,  NAND_ERR = 1, NAND_FAIL = 1;
    localparam int ZERO_N = 1,  ZERO_ERR = 1, ZERO_FAIL = 1;
    localparam int XOR3_N = 6,  XOR3_ERR = 1, XOR3_FAIL = 2,  XOR3_AB = 1;
`else
    localparam int XOR1_N = 16, XOR1_ERR = 2, XOR1_FAIL = 6,  XOR1_AB = 0;
    localparam int NAND_N = 16, NAND_ERR = 4, NAND_FAIL = 15;
    localparam int ZERO_N = 8,  ZERO_ERR = 3, ZERO_FAIL = 15;
    localparam int XOR3_N = 24, XOR3_ERR = 4, XOR3_FAIL = 6,  XOR3_AB = 0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] start;
    logic [2:0] a, b, busy, done, pass;
    logic [1:0] vec_idx [3];
    logic [3:0] fail_vec [3];
    logic [6:0] obs [3];
    logic [6:0] am [3];
    logic [6:0] xm [3];
    logic [7:0] err0, err2;
    logic [1:0] err1;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    function automatic logic [6:0] gate(input logic x, input logic y);
        return {x & y, x | y, ~x, ~(x & y), ~(x | y), x ^ y, ~(x ^ y)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_obs
        assign obs[g] = (gate(a[g], b[g]) & am[g]) ^ xm[g];
    end

    gate_stim_checker #(.HOLD_CYCLES(4), .NUM_PASSES(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .obs(obs[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .vec_idx(vec_idx[0]),
        .fail_vec(fail_vec[0]), .err_count(err0)
    );

    gate_stim_checker #(.HOLD_CYCLES(0), .NUM_PASSES(2), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]), .obs(obs[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .vec_idx(vec_idx[1]),
        .fail_vec(fail_vec[1]), .err_count(err1)
    );

    gate_stim_checker #(.HOLD_CYCLES(3), .NUM_PASSES(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .a(a[2]), .b(b[2]), .obs(obs[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .vec_idx(vec_idx[2]),
        .fail_vec(fail_vec[2]), .err_count(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input int k);
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    // Counts busy cycles from the first busy negedge; bounded.
    task automatic count_busy(input int k, output int cnt);
        cnt = 0;
        while (busy[k] && cnt < 500) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 3; i++) begin
            am[i] = 7'h7F;
            xm[i] = 7'h00;
        end
        #12;
        check("rst_ab", {a[0], b[0]}, 0);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_pass", pass[0], 0);
        check("rst_vec", vec_idx[0], 0);
        check("rst_fail", fail_vec[0], 0);
        check("rst_err", err0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Clean run with an ignored start pulse mid-run.
        start_run(0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t1_busy_%0d", k), busy[0], 1);
            check($sformatf("t1_ab_%0d", k), {a[0], b[0]}, k / 4);
            check($sformatf("t1_vec_%0d", k), vec_idx[0], k / 4);
            if (k == 4) start[0] = 1'b1;
            if (k == 5) start[0] = 1'b0;
            @(negedge clk);
        end
        check("t1_busy_end", busy[0], 0);
        check("t1_done", done[0], 1);
        check("t1_pass", pass[0], 1);
        check("t1_err", err0, 0);
        check("t1_fail", fail_vec[0], 0);
        check("t1_ab_end", {a[0], b[0]}, 0);
        repeat (3) @(negedge clk);
        check("t1_done_hold", done[0], 1);

        // Restart from DONE with xor output stuck at 0.
        am[0] = 7'h7D;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        check("rs_done_clr", done[0], 0);
        check("rs_pass_clr", pass[0], 0);
        check("rs_busy", busy[0], 1);
        check("rs_ab", {a[0], b[0]}, 0);
        @(negedge clk);
        start[0] = 1'b0;
        count_busy(0, n);
        check("xor1_cycles", n, XOR1_N);
        check("xor1_done", done[0], 1);
        check("xor1_pass", pass[0], 0);
        check("xor1_err", err0, XOR1_ERR);
        check("xor1_fail", fail_vec[0], XOR1_FAIL);
        check("xor1_ab", {a[0], b[0]}, XOR1_AB);

        // NAND output inverted.
        am[0] = 7'h7F;
        xm[0] = 7'h08;
        start_run(0);
        count_busy(0, n);
        check("nand_cycles", n, NAND_N);
        check("nand_err", err0, NAND_ERR);
        check("nand_fail", fail_vec[0], NAND_FAIL);
        check("nand_vec", vec_idx[0], 0);
        repeat (3) @(negedge clk);
        check("nand_hold_done", done[0], 1);
        check("nand_hold_ab", {a[0], b[0]}, 0);

        // Asynchronous reset mid-run after an error has been counted.
        start_run(0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_ab", {a[0], b[0]}, 0);
        check("ar_busy", busy[0], 0);
        check("ar_done", done[0], 0);
        check("ar_err", err0, 0);
        check("ar_fail", fail_vec[0], 0);
        @(negedge clk);
        rst = 1'b0;
        xm[0] = 7'h00;
        start_run(0);
        count_busy(0, n);
        check("ar_rerun_cycles", n, 16);
        check("ar_rerun_pass", pass[0], 1);
        check("ar_rerun_err", err0, 0);

        // HOLD_CYCLES=0 behaves as 1; clean two-pass run.
        start_run(1);
        count_busy(1, n);
        check("h0_cycles", n, 8);
        check("h0_pass", pass[1], 1);

        // obs forced to zero with a 2-bit counter.
        am[1] = 7'h00;
        start_run(1);
        count_busy(1, n);
        check("sat_cycles", n, ZERO_N);
        check("sat_err", err1, ZERO_ERR);
        check("sat_fail", fail_vec[1], ZERO_FAIL);
        check("sat_pass", pass[1], 0);

        // Two-pass sweep with xor stuck at 0.
        am[2] = 7'h7D;
        start_run(2);
        count_busy(2, n);
        check("xor3_cycles", n, XOR3_N);
        check("xor3_done", done[2], 1);
        check("xor3_err", err2, XOR3_ERR);
        check("xor3_fail", fail_vec[2], XOR3_FAIL);
        check("xor3_pass", pass[2], 0);
        check("xor3_ab", {a[2], b[2]}, XOR3_AB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
